// File: rtl/cdb_arbiter_pkg.sv
// Shared ROB/data widths, constants and entry types for the CDB arbiter slice.
// Widths are fixed here; the arbiter and its buffers add none of their own.
package cdb_arbiter_pkg;

  typedef logic [3:0]  ROB_ID_TYPE;
  typedef logic [31:0] DATA_TYPE;

  localparam ROB_ID_TYPE ZERO_ROB  = 4'd0;
  localparam DATA_TYPE   ZERO_WORD = 32'd0;
  localparam logic       TRUE      = 1'b1;
  localparam logic       FALSE     = 1'b0;

  typedef struct packed {
    ROB_ID_TYPE rob_id;
    DATA_TYPE   result;
  } cdb_entry_t;

  localparam int ENTRY_W = $bits(cdb_entry_t);

  typedef enum logic {
    PRIO_ALU = 1'b0,
    PRIO_LS  = 1'b1
  } prio_e;

  function automatic prio_e prio_other(input prio_e p);
    return (p == PRIO_ALU) ? PRIO_LS : PRIO_ALU;
  endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Per-requester result buffer: DEPTH entries, same-cycle push+pop, flush empties it.
// full/empty come from registered occupancy only, so ready never depends on a same-cycle pop.
module cdb_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               flush,
  input  logic               push,
  input  logic               pop,
  input  logic [ENTRY_W-1:0] push_dat,
  output logic               full,
  output logic               empty,
  output logic [ENTRY_W-1:0] head_dat
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;
  cdb_entry_t    mem_q [DEPTH];

  assign full     = (cnt_q == (PW+1)'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign head_dat = mem_q[rd_q];

  assign do_push = en && !flush && push && !full;
  assign do_pop  = en && !flush && pop && !empty;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (do_push) wr_d = wr_q + PW'(1);
      if (do_pop)  rd_d = rd_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + (PW+1)'(1);
        2'b01:   cnt_d = cnt_q - (PW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= cdb_entry_t'(push_dat);
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter of ALU and LS results onto one registered CDB; 2-edge uncontended latency.
// Optional saturating conflict counter enabled by defining CDB_ARB_PERF_CNT_EN.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        misbranch_flag,
  input  logic        alu_valid,
  input  logic [3:0]  alu_rob_id,
  input  logic [31:0] alu_result,
  output logic        alu_ready,
  input  logic        ls_valid,
  input  logic [3:0]  ls_rob_id,
  input  logic [31:0] ls_result,
  output logic        ls_ready,
  output logic        cdb_valid,
  output logic [3:0]  cdb_rob_id,
  output logic [31:0] cdb_result
`ifdef CDB_ARB_PERF_CNT_EN
  ,
  output logic [31:0] conflict_cnt
`endif
);

  logic               alu_full, alu_empty, ls_full, ls_empty;
  logic               alu_push, ls_push;
  logic               grant_alu, grant_ls;
  logic [ENTRY_W-1:0] alu_head, ls_head;
  cdb_entry_t         alu_ent, ls_ent, alu_in, ls_in;

  prio_e              prio_q, prio_d;
  logic               cdb_valid_q, cdb_valid_d;
  ROB_ID_TYPE         cdb_rob_id_q, cdb_rob_id_d;
  DATA_TYPE           cdb_result_q, cdb_result_d;

  assign alu_ready = rdy && !alu_full;
  assign ls_ready  = rdy && !ls_full;

  // Offers tagged with the null ROB id are accepted on the handshake but never stored.
  assign alu_push = alu_valid && alu_ready && (alu_rob_id != ZERO_ROB) && !misbranch_flag;
  assign ls_push  = ls_valid  && ls_ready  && (ls_rob_id  != ZERO_ROB) && !misbranch_flag;

  assign alu_in  = '{rob_id: alu_rob_id, result: alu_result};
  assign ls_in   = '{rob_id: ls_rob_id,  result: ls_result};
  assign alu_ent = cdb_entry_t'(alu_head);
  assign ls_ent  = cdb_entry_t'(ls_head);

  cdb_fifo #(.DEPTH(FIFO_DEPTH)) u_alu_fifo (
    .clk      (clk),
    .rst      (rst),
    .en       (rdy),
    .flush    (misbranch_flag),
    .push     (alu_push),
    .pop      (grant_alu),
    .push_dat (alu_in),
    .full     (alu_full),
    .empty    (alu_empty),
    .head_dat (alu_head)
  );

  cdb_fifo #(.DEPTH(FIFO_DEPTH)) u_ls_fifo (
    .clk      (clk),
    .rst      (rst),
    .en       (rdy),
    .flush    (misbranch_flag),
    .push     (ls_push),
    .pop      (grant_ls),
    .push_dat (ls_in),
    .full     (ls_full),
    .empty    (ls_empty),
    .head_dat (ls_head)
  );

  always_comb begin
    grant_alu = FALSE;
    grant_ls  = FALSE;
    if (rdy && !misbranch_flag) begin
      if (!alu_empty && !ls_empty) begin
        if (prio_q == PRIO_ALU) grant_alu = TRUE;
        else                    grant_ls  = TRUE;
      end else if (!alu_empty) begin
        grant_alu = TRUE;
      end else if (!ls_empty) begin
        grant_ls = TRUE;
      end
    end
  end

  always_comb begin
    prio_d       = prio_q;
    cdb_valid_d  = cdb_valid_q;
    cdb_rob_id_d = cdb_rob_id_q;
    cdb_result_d = cdb_result_q;
    if (misbranch_flag) begin
      cdb_valid_d = FALSE;
      prio_d      = PRIO_ALU;
    end else if (rdy) begin
      cdb_valid_d = grant_alu || grant_ls;
      if (grant_alu) begin
        cdb_rob_id_d = alu_ent.rob_id;
        cdb_result_d = alu_ent.result;
        prio_d       = prio_other(PRIO_ALU);
      end else if (grant_ls) begin
        cdb_rob_id_d = ls_ent.rob_id;
        cdb_result_d = ls_ent.result;
        prio_d       = prio_other(PRIO_LS);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q       <= PRIO_ALU;
      cdb_valid_q  <= FALSE;
      cdb_rob_id_q <= ZERO_ROB;
      cdb_result_q <= ZERO_WORD;
    end else begin
      prio_q       <= prio_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_rob_id_q <= cdb_rob_id_d;
      cdb_result_q <= cdb_result_d;
    end
  end

  assign cdb_valid  = cdb_valid_q;
  assign cdb_rob_id = cdb_rob_id_q;
  assign cdb_result = cdb_result_q;

`ifdef CDB_ARB_PERF_CNT_EN
  logic [31:0] conflict_cnt_q, conflict_cnt_d;

  // Counts arbitrated cycles where both requesters had work; survives flushes.
  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (rdy && !misbranch_flag && !alu_empty && !ls_empty && (conflict_cnt_q != 32'hFFFF_FFFF))
      conflict_cnt_d = conflict_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) conflict_cnt_q <= 32'd0;
    else     conflict_cnt_q <= conflict_cnt_d;
  end

  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed table-driven bench for cdb_arbiter (FIFO_DEPTH=2) plus hand sequences for reset
// override and, when CDB_ARB_PERF_CNT_EN is defined, the conflict counter.
module tb_cdb_arbiter;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        misbranch_flag;
  logic        alu_valid;
  logic [3:0]  alu_rob_id;
  logic [31:0] alu_result;
  logic        alu_ready;
  logic        ls_valid;
  logic [3:0]  ls_rob_id;
  logic [31:0] ls_result;
  logic        ls_ready;
  logic        cdb_valid;
  logic [3:0]  cdb_rob_id;
  logic [31:0] cdb_result;
`ifdef CDB_ARB_PERF_CNT_EN
  logic [31:0] conflict_cnt;
`endif

  int errors = 0;
  int checks = 0;

  cdb_arbiter #(.FIFO_DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .misbranch_flag (misbranch_flag),
    .alu_valid      (alu_valid),
    .alu_rob_id     (alu_rob_id),
    .alu_result     (alu_result),
    .alu_ready      (alu_ready),
    .ls_valid       (ls_valid),
    .ls_rob_id      (ls_rob_id),
    .ls_result      (ls_result),
    .ls_ready       (ls_ready),
    .cdb_valid      (cdb_valid),
    .cdb_rob_id     (cdb_rob_id),
    .cdb_result     (cdb_result)
`ifdef CDB_ARB_PERF_CNT_EN
    ,
    .conflict_cnt   (conflict_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [3:0]  aid;
    logic [31:0] ares;
    logic        lv;
    logic [3:0]  lid;
    logic [31:0] lres;
    logic        en;
    logic        mb;
    logic        e_ar;
    logic        e_lr;
    logic        e_v;
    logic [3:0]  e_id;
    logic [31:0] e_res;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic av, input logic [3:0] aid, input logic [31:0] ares,
                     input logic lv, input logic [3:0] lid, input logic [31:0] lres,
                     input logic en, input logic mb, input logic e_ar, input logic e_lr,
                     input logic e_v, input logic [3:0] e_id, input logic [31:0] e_res);
    vec_t v;
    v.av = av; v.aid = aid; v.ares = ares;
    v.lv = lv; v.lid = lid; v.lres = lres;
    v.en = en; v.mb = mb;
    v.e_ar = e_ar; v.e_lr = e_lr;
    v.e_v = e_v; v.e_id = e_id; v.e_res = e_res;
    vq.push_back(v);
  endtask

  task automatic idle(input logic en, input logic e_ar, input logic e_lr,
                      input logic e_v, input logic [3:0] e_id, input logic [31:0] e_res);
    add(0, 0, 0, 0, 0, 0, en, 0, e_ar, e_lr, e_v, e_id, e_res);
  endtask

  task automatic drive(input logic av, input logic [3:0] aid, input logic [31:0] ares,
                       input logic lv, input logic [3:0] lid, input logic [31:0] lres,
                       input logic en, input logic mb);
    alu_valid = av; alu_rob_id = aid; alu_result = ares;
    ls_valid = lv; ls_rob_id = lid; ls_result = lres;
    rdy = en; misbranch_flag = mb;
  endtask

  // Readys are checked before the edge; cdb_* just after it.
  task automatic apply(input int idx, input vec_t v);
    drive(v.av, v.aid, v.ares, v.lv, v.lid, v.lres, v.en, v.mb);
    #1;
    chk($sformatf("v%0d alu_ready", idx), {31'd0, alu_ready}, {31'd0, v.e_ar});
    chk($sformatf("v%0d ls_ready", idx), {31'd0, ls_ready}, {31'd0, v.e_lr});
    @(posedge clk);
    #1;
    chk($sformatf("v%0d cdb_valid", idx), {31'd0, cdb_valid}, {31'd0, v.e_v});
    chk($sformatf("v%0d cdb_rob_id", idx), {28'd0, cdb_rob_id}, {28'd0, v.e_id});
    chk($sformatf("v%0d cdb_result", idx), cdb_result, v.e_res);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset cdb_valid", {31'd0, cdb_valid}, 32'd0);
    chk("reset cdb_rob_id", {28'd0, cdb_rob_id}, 32'd0);
    chk("reset cdb_result", cdb_result, 32'd0);
    chk("reset alu_ready", {31'd0, alu_ready}, 32'd1);
    chk("reset ls_ready", {31'd0, ls_ready}, 32'd1);
`ifdef CDB_ARB_PERF_CNT_EN
    chk("reset conflict_cnt", conflict_cnt, 32'd0);
`endif
    rst = 1'b0;

    // Single ALU result: two-edge latency, then bus idles.
    add(1, 3, 32'h11, 0, 0, 0, 1, 0, 1, 1, 0, 0, 32'h0);
    idle(1, 1, 1, 1, 3, 32'h11);
    idle(1, 1, 1, 0, 3, 32'h11);
    // LS-only result moves the pointer back to ALU.
    add(0, 0, 0, 1, 5, 32'h55, 1, 0, 1, 1, 0, 3, 32'h11);
    idle(1, 1, 1, 1, 5, 32'h55);
    // Simultaneous offers with pointer on ALU.
    add(1, 1, 32'hA, 1, 2, 32'hB, 1, 0, 1, 1, 0, 5, 32'h55);
    idle(1, 1, 1, 1, 1, 32'hA);
    idle(1, 1, 1, 1, 2, 32'hB);
    idle(1, 1, 1, 0, 2, 32'hB);
    // Both valid for 8 cycles; rejected offers are held until accepted.
    add(1, 1, 32'h101, 1,  9, 32'h209, 1, 0, 1, 1, 0,  2, 32'hB);
    add(1, 2, 32'h102, 1, 10, 32'h20A, 1, 0, 1, 1, 1,  1, 32'h101);
    add(1, 3, 32'h103, 1, 11, 32'h20B, 1, 0, 1, 0, 1,  9, 32'h209);
    add(1, 4, 32'h104, 1, 11, 32'h20B, 1, 0, 0, 1, 1,  2, 32'h102);
    add(1, 4, 32'h104, 1, 12, 32'h20C, 1, 0, 1, 0, 1, 10, 32'h20A);
    add(1, 5, 32'h105, 1, 12, 32'h20C, 1, 0, 0, 1, 1,  3, 32'h103);
    add(1, 5, 32'h105, 1, 13, 32'h20D, 1, 0, 1, 0, 1, 11, 32'h20B);
    add(1, 6, 32'h106, 1, 13, 32'h20D, 1, 0, 0, 1, 1,  4, 32'h104);
    idle(1, 1, 0, 1, 12, 32'h20C);
    idle(1, 1, 1, 1,  5, 32'h105);
    idle(1, 1, 1, 1, 13, 32'h20D);
    idle(1, 1, 1, 0, 13, 32'h20D);
    // Entries pending in both FIFOs, then a flush with ignored offers.
    add(1, 6, 32'h106, 1, 14, 32'h20E, 1, 0, 1, 1, 0, 13, 32'h20D);
    add(1, 7, 32'h107, 1, 15, 32'h20F, 1, 0, 1, 1, 1,  6, 32'h106);
    add(1, 8, 32'h108, 1,  1, 32'h201, 1, 1, 1, 0, 0,  6, 32'h106);
    idle(1, 1, 1, 0, 6, 32'h106);
    idle(1, 1, 1, 0, 6, 32'h106);
    // Pointer was reset to ALU by the flush.
    add(1, 8, 32'h108, 1, 7, 32'h207, 1, 0, 1, 1, 0, 6, 32'h106);
    idle(1, 1, 1, 1, 8, 32'h108);
    idle(1, 1, 1, 1, 7, 32'h207);
    idle(1, 1, 1, 0, 7, 32'h207);
    // Freeze for 3 cycles with an LS entry pending and a valid broadcast on the bus.
    add(1, 9, 32'h109, 1, 12, 32'h212, 1, 0, 1, 1, 0, 7, 32'h207);
    idle(1, 1, 1, 1, 9, 32'h109);
    idle(0, 0, 0, 1, 9, 32'h109);
    add(1, 13, 32'h10D, 0, 0, 0, 0, 0, 0, 0, 1, 9, 32'h109);
    idle(0, 0, 0, 1, 9, 32'h109);
    idle(1, 1, 1, 1, 12, 32'h212);
    // Null ROB id is never broadcast.
    add(1, 0, 32'h0EE, 0, 0, 0, 1, 0, 1, 1, 0, 12, 32'h212);
    idle(1, 1, 1, 0, 12, 32'h212);
    idle(1, 1, 1, 0, 12, 32'h212);

    foreach (vq[i]) apply(i, vq[i]);

    // Reset overrides misbranch and rdy=0 and discards a pending entry.
    drive(1, 5, 32'h105, 0, 0, 0, 1, 0);
    @(posedge clk);
    #1;
    chk("pre-rst cdb_valid", {31'd0, cdb_valid}, 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst cdb_valid", {31'd0, cdb_valid}, 32'd0);
    chk("rst cdb_rob_id", {28'd0, cdb_rob_id}, 32'd0);
    chk("rst cdb_result", cdb_result, 32'd0);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    #1;
    chk("post-rst alu_ready", {31'd0, alu_ready}, 32'd1);
    @(posedge clk);
    #1;
    chk("post-rst cdb_valid", {31'd0, cdb_valid}, 32'd0);

`ifdef CDB_ARB_PERF_CNT_EN
    // Both FIFOs non-empty at four consecutive arbitration edges.
    drive(1, 1, 32'h101, 1, 9, 32'h209, 1, 0);
    @(posedge clk); #1;
    drive(1, 2, 32'h102, 1, 10, 32'h20A, 1, 0);
    @(posedge clk); #1;
    drive(1, 3, 32'h103, 0, 0, 0, 1, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 1, 11, 32'h20B, 1, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    @(posedge clk); #1;
    chk("perf conflict_cnt", conflict_cnt, 32'd4);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    @(posedge clk); #1;
    chk("perf after flush", conflict_cnt, 32'd4);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    @(posedge clk); #1;
    chk("perf idle hold", conflict_cnt, 32'd4);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
